lut_config_ctrl: RTL and testbench
==================================

LUT_CONFIG_CTRL -- requirements
Module: lut_config_ctrl

Interface
REQ-001 Parameter K, default 6: LUT input count; each LUTRAM holds 2**K bits.
REQ-002 Parameter NUM_LUTS, default 8: number of LUTRAMs served (2..256).
REQ-003 Parameter SEL_W, default 3: width of LUT index, SEL_W = clog2(NUM_LUTS).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cfg_valid  input  1  mask word offered.
REQ-007 cfg_ready  output  1  controller accepts word this cycle.
REQ-008 cfg_mask  input  2**K  LUT contents; bit i is written to address i.
REQ-009 cfg_sel  input  SEL_W  target LUT index.
REQ-010 cfg_parity  input  1  even parity of cfg_mask (used only under REQ-030).
REQ-011 lut_a  output  K  LUTRAM write address.
REQ-012 lut_d  output  1  LUTRAM write data.
REQ-013 lut_we  output  NUM_LUTS  one-hot write enable, bit n drives LUT n.
REQ-014 busy  output  1  write burst in progress.
REQ-015 done  output  1  one-cycle pulse after final bit of a word written.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 States SHALL be IDLE, WRITE, FINISH; reset state IDLE.
REQ-018 IDLE: cfg_ready=1; on cfg_valid&cfg_ready, latch cfg_mask/cfg_sel, clear address counter to 0, go WRITE.
REQ-019 cfg_sel >= NUM_LUTS at acceptance: word consumed, no write, err set, remain IDLE.
REQ-020 WRITE: each cycle lut_a=counter, lut_d=mask[counter], lut_we[sel]=1, all other we bits 0; counter increments.
REQ-021 WRITE lasts exactly 2**K cycles; counter wraps from 2**K-1 to 0 and state goes FINISH.
REQ-022 FINISH: one cycle, done=1, lut_we=0, then IDLE.
REQ-023 Latency: acceptance at edge T -> first we at cycle T+1, last at T+2**K, done at T+2**K+1, cfg_ready high again at T+2**K+2.
REQ-024 cfg_ready SHALL be 0 in WRITE and FINISH; cfg_valid there is ignored and not lost by source (held per valid/ready rules).
REQ-025 busy=1 in WRITE and FINISH, else 0.
REQ-026 lut_we SHALL never have more than one bit set; outside WRITE all bits 0.
REQ-027 err clears only on reset.

Reset
REQ-028 Reset assertion, including mid-burst, SHALL immediately force IDLE, counter 0, lut_a=0, lut_d=0, lut_we=0, busy=0, done=0, err=0, cfg_ready deasserted while reset held; partially written LUT contents are undefined and must be reloaded.
REQ-029 First acceptance possible on first rising clk edge after reset deasserts.

Configuration
REQ-030 Macro ZUMA_CFG_PARITY_EN: when defined, at acceptance the XOR of cfg_mask and cfg_parity is checked; nonzero -> word dropped, no write, err set, stay IDLE. When undefined, cfg_parity is ignored and no parity logic is built; behaviour otherwise identical.

Verification
REQ-031 K=6, NUM_LUTS=8: mask 64'hA5A5_0000_FFFF_1234 to sel 3 -> lut_we[3] high 64 cycles, lut_a 0..63, lut_d matches mask bits, done at T+65.
REQ-032 Back-to-back: two words held valid (sel 0, sel 7) -> second accepted at T+66, no overlap of we bits, two done pulses 66 cycles apart.
REQ-033 Reset asserted at 20th write cycle -> same cycle lut_we=0, busy=0; next word after release writes full 64 bits from address 0.
REQ-034 cfg_sel=8 with NUM_LUTS=8 -> no lut_we activity, err=1 held until reset, cfg_ready stays 1.
REQ-035 ZUMA_CFG_PARITY_EN defined, mask 64'h1 with cfg_parity=0 -> word dropped, err=1; with cfg_parity=1 -> written normally, err unchanged.
REQ-036 ZUMA_CFG_PARITY_EN undefined, same wrong-parity word -> written normally, err=0.

Source files
------------

// File: rtl/lut_config_ctrl.sv
// lut_config_ctrl: streams a 2**K-bit mask one bit per cycle into one of NUM_LUTS LUTRAMs.
// Optional feature macro ZUMA_CFG_PARITY_EN rejects words whose mask fails even parity.
module lut_config_ctrl #(
  parameter int K        = 6,
  parameter int NUM_LUTS = 8,
  parameter int SEL_W    = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [2**K-1:0]     cfg_mask_i,
  input  logic [SEL_W-1:0]    cfg_sel_i,
  input  logic                cfg_parity_i,
  output logic [K-1:0]        lut_a_o,
  output logic                lut_d_o,
  output logic [NUM_LUTS-1:0] lut_we_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_e;
  state_e              state_q;
  logic [2**K-1:0]     mask_q;
  logic [K-1:0]        lut_a_q;
  logic [NUM_LUTS-1:0] lut_we_q;
  logic                lut_d_q, busy_q, done_q, err_q;
  logic                sel_bad, reject;
  assign sel_bad = {1'b0, cfg_sel_i} >= (SEL_W+1)'(NUM_LUTS);
`ifdef ZUMA_CFG_PARITY_EN
  assign reject = sel_bad | (^cfg_mask_i ^ cfg_parity_i);
`else
  logic unused_parity;
  assign unused_parity = cfg_parity_i;
  assign reject = sel_bad;
`endif
  // Ready is combinational so a word can be taken on the very first edge after reset.
  assign cfg_ready_o = ~reset_i & (state_q == IDLE);
  assign lut_a_o     = lut_a_q;
  assign lut_d_o     = lut_d_q;
  assign lut_we_o    = lut_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      lut_a_q  <= '0;
      lut_d_q  <= 1'b0;
      lut_we_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid_i) begin
          if (reject) err_q <= 1'b1;
          else begin
            state_q  <= WRITE;
            mask_q   <= cfg_mask_i;
            lut_a_q  <= '0;
            lut_d_q  <= cfg_mask_i[0];
            lut_we_q <= NUM_LUTS'(1) << cfg_sel_i;
            busy_q   <= 1'b1;
          end
        end
        WRITE: if (&lut_a_q) begin
          state_q  <= FINISH;
          lut_a_q  <= '0;
          lut_d_q  <= 1'b0;
          lut_we_q <= '0;
          done_q   <= 1'b1;
        end else begin
          lut_a_q <= lut_a_q + 1'b1;
          lut_d_q <= mask_q[lut_a_q + 1'b1];
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_config_ctrl.sv
// tb_lut_config_ctrl: randomized, cycle-exact checks of lut_config_ctrl against a word-level model.
module tb_lut_config_ctrl;
  localparam int K  = 6;
  localparam int N  = 8;
  localparam int SW = 4;  // one bit wider than clog2 so out-of-range selects such as 8 are drivable
  localparam int D  = 2**K;
  logic          clk = 1'b0, reset_i = 1'b1, cfg_valid_i = 1'b0, cfg_parity_i = 1'b0;
  logic          cfg_ready_o, lut_d_o, busy_o, done_o, err_o;
  logic [D-1:0]  cfg_mask_i = '0;
  logic [SW-1:0] cfg_sel_i = '0;
  logic [K-1:0]  lut_a_o;
  logic [N-1:0]  lut_we_o;
  logic          exp_err = 1'b0;
  int            errors = 0, checks = 0, cyc = 0, last_done = 0;
  lut_config_ctrl #(.K(K), .NUM_LUTS(N), .SEL_W(SW)) dut (
    .clk_i(clk), .reset_i(reset_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_mask_i(cfg_mask_i), .cfg_sel_i(cfg_sel_i), .cfg_parity_i(cfg_parity_i),
    .lut_a_o(lut_a_o), .lut_d_o(lut_d_o), .lut_we_o(lut_we_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not reach its summary");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] pack(input logic b, input logic r, input logic dn, input logic e,
                                       input logic [N-1:0] we, input logic [K-1:0] a, input logic d);
    return 64'({b, r, dn, e, we, a, d});
  endfunction
  function automatic logic [63:0] obs();
    return pack(busy_o, cfg_ready_o, done_o, err_o, lut_we_o, lut_a_o, lut_d_o);
  endfunction
  function automatic bit bad(input logic [D-1:0] m, input int s, input logic p);
    bit pe = 1'b0;
`ifdef ZUMA_CFG_PARITY_EN
    pe = (^m) != p;
`endif
    return s >= N || pe;
  endfunction
  task automatic offer(input logic [D-1:0] m, input int s, input logic p);
    cfg_valid_i  = 1'b1;
    cfg_mask_i   = m;
    cfg_sel_i    = SW'(s);
    cfg_parity_i = p;
  endtask
  task automatic expect_burst(input logic [D-1:0] m, input int s);
    logic [N-1:0] we;
    we = N'(1) << s;
    for (int i = 0; i < D; i++) begin
      check("write", obs(), pack(1, 0, 0, exp_err, we, K'(i), m[i]));
      @(negedge clk);
    end
    check("finish", obs(), pack(1, 0, 1, exp_err, '0, '0, 0));
    last_done = cyc;
    @(negedge clk);
    check("idle", obs(), pack(0, 1, 0, exp_err, '0, '0, 0));
  endtask
  task automatic send(input logic [D-1:0] m, input int s, input logic p);
    offer(m, s, p);
    #1 check("ready", 64'(cfg_ready_o), 64'd1);
    @(negedge clk);
    cfg_valid_i = 1'b0;
    if (bad(m, s, p)) begin
      exp_err = 1'b1;
      check("drop", obs(), pack(0, 1, 0, 1, '0, '0, 0));
    end else expect_burst(m, s);
    @(negedge clk);
  endtask
  initial begin
    logic [D-1:0] m, mb;
    int s, d1;
    repeat (2) @(negedge clk);
    check("reset", obs(), pack(0, 0, 0, 0, '0, '0, 0));
    reset_i = 1'b0;
    m = 64'hA5A5_0000_FFFF_1234;
    send(m, 3, ^m);
    m  = {$urandom, $urandom};
    mb = {$urandom, $urandom};
    offer(m, 0, ^m);
    #1 check("b2b_ready", 64'(cfg_ready_o), 64'd1);
    @(negedge clk);
    offer(mb, 7, ^mb);
    expect_burst(m, 0);
    d1 = last_done;
    @(negedge clk);
    cfg_valid_i = 1'b0;
    expect_burst(mb, 7);
    check("b2b_gap", 64'(last_done - d1), 64'd66);
    @(negedge clk);
    send(64'h1, 0, 1'b0);
    send(64'h1, 1, 1'b1);
    send({$urandom, $urandom}, 8, 1'b0);
    check("sticky_err", 64'(err_o), 64'd1);
    for (int n = 0; n < 12; n++) begin
      m = {$urandom, $urandom};
      s = ($urandom % 4 == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      send(m, s, (^m) ^ ($urandom % 4 == 0));
    end
    m = {$urandom, $urandom};
    offer(m, 5, ^m);
    @(negedge clk);
    cfg_valid_i = 1'b0;
    for (int i = 0; i < 19; i++) begin
      check("pre_rst", obs(), pack(1, 0, 0, exp_err, N'(1) << 5, K'(i), m[i]));
      @(negedge clk);
    end
    reset_i = 1'b1;
    exp_err = 1'b0;
    #1 check("rst_mid", obs(), pack(0, 0, 0, 0, '0, '0, 0));
    @(negedge clk);
    reset_i = 1'b0;
    m = {$urandom, $urandom};
    send(m, 2, ^m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
